// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
// Requester indices are 2-bit values, and the pointer wraps modulo 4.
package rr_mux_arbiter_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] sel_t;

    // Modulo-4 increment; the 2-bit width gives the wrap for free.
    function automatic sel_t next_idx(input sel_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: rotate so the slot after last_grant sits at bit 0,
// take the lowest set bit, then add the rotation back.
module rr_pick_4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req_valid,
    input  sel_t             last_grant,
    output sel_t             grant,
    output logic             any_req
);

    sel_t                   start_s;
    logic [2*N_REQ-1:0]     dbl_s;
    logic [N_REQ-1:0]       rot_s;
    sel_t                   off_s;

    assign start_s = next_idx(last_grant);
    assign dbl_s   = {req_valid, req_valid};
    assign rot_s   = dbl_s[start_s +: N_REQ];
    assign any_req = |req_valid;

    // Fixed-priority encode of the rotated vector; bit 0 is the highest priority.
    always_comb begin
        off_s = 2'd0;
        if (rot_s[0]) begin
            off_s = 2'd0;
        end else if (rot_s[1]) begin
            off_s = 2'd1;
        end else if (rot_s[2]) begin
            off_s = 2'd2;
        end else if (rot_s[3]) begin
            off_s = 2'd3;
        end else begin
            off_s = 2'd0;
        end
    end

    assign grant = start_s + off_s;

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter driving a shared 4:1 data mux into a one-entry registered output
// stage. A new word can be loaded in the same cycle that the held word drains.
module rr_mux_arbiter_4
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    sel_t             out_sel_r;
    sel_t             last_grant_r;

    sel_t             grant_s;
    logic             any_req_s;
    logic             can_load_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sel_data_s;

    rr_pick_4 u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .any_req    (any_req_s)
    );

    assign can_load_s = !out_valid_r || out_ready;
    assign xfer_s     = can_load_s && any_req_s && !rst;

    // One-hot ready for the granted requester; nothing is accepted while in reset.
    always_comb begin
        req_ready = 4'b0000;
        if (xfer_s) begin
            case (grant_s)
                2'd0:    req_ready = 4'b0001;
                2'd1:    req_ready = 4'b0010;
                2'd2:    req_ready = 4'b0100;
                2'd3:    req_ready = 4'b1000;
                default: req_ready = 4'b0000;
            endcase
        end else begin
            req_ready = 4'b0000;
        end
    end

    // Data mux: only the granted input is routed, so unselected X cannot leak through.
    always_comb begin
        sel_data_s = '0;
        case (grant_s)
            2'd0:    sel_data_s = d0;
            2'd1:    sel_data_s = d1;
            2'd2:    sel_data_s = d2;
            2'd3:    sel_data_s = d3;
            default: sel_data_s = '0;
        endcase
    end

    // Output stage and round-robin pointer; the pointer moves only on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_sel_r    <= 2'd0;
            last_grant_r <= 2'd3;
        end else if (xfer_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= sel_data_s;
            out_sel_r    <= grant_s;
            last_grant_r <= grant_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r  <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Scoreboard bench for rr_mux_arbiter_4: an independent reference model predicts each grant,
// queues the expected word at acceptance and compares it once it appears at the output.
module tb_rr_mux_arbiter_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    int n_pass  = 0;
    int n_total = 0;

    logic         m_valid;
    logic [W-1:0] m_data;
    logic [1:0]   m_sel;
    logic [1:0]   m_last;
    logic [W+1:0] sb_q[$];

    always #5 clk = ~clk;

    rr_mux_arbiter_4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scan last+1 .. last+4; iterating downwards lets the nearest requester win.
    function automatic logic [1:0] model_grant(input logic [3:0] rv);
        logic [1:0] idx;
        model_grant = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = m_last + k[1:0];
            if (rv[idx]) model_grant = idx;
        end
    endfunction

    function automatic logic [W-1:0] word(input logic [1:0] g);
        case (g)
            2'd0:    word = d0;
            2'd1:    word = d1;
            2'd2:    word = d2;
            default: word = d3;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check ready, advance the model at posedge, check outputs.
    task automatic step(input logic r, input logic [3:0] rv, input logic ordy);
        logic [1:0]   g;
        logic [3:0]   exp_rdy;
        logic         xfer;
        logic [W+1:0] e;
        rst       = r;
        req_valid = rv;
        out_ready = ordy;
        #1;
        g       = model_grant(rv);
        xfer    = !r && (!m_valid || ordy) && (rv != 4'b0000);
        exp_rdy = xfer ? (4'b0001 << g) : 4'b0000;
        check_eq("req_ready", {4'b0000, req_ready}, {4'b0000, exp_rdy});
        if (xfer) sb_q.push_back({g, word(g)});
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 2'd0;
            m_last  = 2'd3;
        end else if (xfer) begin
            e       = sb_q.pop_front();
            m_valid = 1'b1;
            m_sel   = e[W+1:W];
            m_data  = e[W-1:0];
            m_last  = g;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
        check_eq("out_sel",   {6'd0, out_sel},   {6'd0, m_sel});
        check_eq("out_data",  {4'd0, out_data},  {4'd0, m_data});
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
        m_valid = 1'b0; m_data = '0; m_sel = 2'd0; m_last = 2'd3;
        @(negedge clk);

        // Reset with all requesters valid.
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b1);

        // Full rotation: 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, 1'b1);

        // Sparse: park the pointer on 1, then 1010 alternates 3,1 and 0100 sticks on 2.
        step(1'b0, 4'b0010, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1010, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 1'b1);

        // Backpressure: hold 'hb from requester 1 for three cycles, then release.
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b1);
        step(1'b0, 4'b0000, 1'b1);

        // X isolation on d3, then drain with no requests.
        d0 = 4'h7;
        d3 = 4'bxxxx;
        step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        d3 = 4'hd;

        // Reset during a stall discards the held word; requester 0 wins first afterwards.
        step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b1);
        step(1'b0, 4'b1111, 1'b1);

        check_eq("sb_empty", {7'd0, (sb_q.size() == 0)}, 8'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
